// File: rtl/itlb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : itlb_pkg                                                       |
// | Purpose : Shared types and constants for the set-associative             |
// |           instruction TLB (instr_tlb_sa) and its sub-modules.            |
// |           Holds default geometry, flag bit positions, the tag/data       |
// |           entry structs and the flush-walk FSM state enum.               |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package itlb_pkg;

  // Default geometry. The entry structs below are sized from these, so the
  // top-level parameters must keep these values for the structs to line up.
  localparam int ITLB_ASSOC  = 4;
  localparam int ITLB_SETS   = 16;
  localparam int ITLB_VPN_W  = 20;
  localparam int ITLB_PPN_W  = 22;
  localparam int ITLB_ASID_W = 9;
  localparam int ITLB_SET_W  = $clog2(ITLB_SETS);
  localparam int ITLB_TAG_W  = ITLB_VPN_W - ITLB_SET_W;

  // Flag bit positions inside the 3-bit {G,U,X} flag field.
  localparam int FLAG_G = 2;
  localparam int FLAG_U = 1;
  localparam int FLAG_X = 0;

  typedef struct packed {
    logic                   valid;
    logic [ITLB_TAG_W-1:0]  tag;
    logic [ITLB_ASID_W-1:0] asid;
  } itlb_tag_entry_t;

  typedef struct packed {
    logic [ITLB_PPN_W-1:0] ppn;
    logic [2:0]            flags;
  } itlb_data_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } itlb_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_tlb_sa_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : instr_tlb_sa_if                                              |
// | Purpose   : Groups the lookup, refill and flush signals of instr_tlb_sa. |
// | Ports     : none; modport slave is the TLB side, modport master is the   |
// |             requester side.                                              |
// |             lookup : i_lookup_valid, i_lookup_vpn, i_asid                 |
// |             result : o_hit_valid, o_hit, o_ppn, o_flags                   |
// |             refill : i_fill_valid/o_fill_ready + vpn/asid/ppn/flags       |
// |             flush  : i_flush_all, i_flush_asid, i_flush_asid_id, o_busy   |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface instr_tlb_sa_if
  import itlb_pkg::*;
#(
  parameter int VPN_W  = ITLB_VPN_W,
  parameter int PPN_W  = ITLB_PPN_W,
  parameter int ASID_W = ITLB_ASID_W
) ();

  logic              i_lookup_valid;
  logic [VPN_W-1:0]  i_lookup_vpn;
  logic [ASID_W-1:0] i_asid;
  logic              o_hit_valid;
  logic              o_hit;
  logic [PPN_W-1:0]  o_ppn;
  logic [2:0]        o_flags;

  logic              i_fill_valid;
  logic              o_fill_ready;
  logic [VPN_W-1:0]  i_fill_vpn;
  logic [ASID_W-1:0] i_fill_asid;
  logic [PPN_W-1:0]  i_fill_ppn;
  logic [2:0]        i_fill_flags;

  logic              i_flush_all;
  logic              i_flush_asid;
  logic [ASID_W-1:0] i_flush_asid_id;
  logic              o_busy;

  modport slave (
    input  i_lookup_valid, i_lookup_vpn, i_asid,
    output o_hit_valid, o_hit, o_ppn, o_flags,
    input  i_fill_valid, i_fill_vpn, i_fill_asid, i_fill_ppn, i_fill_flags,
    output o_fill_ready,
    input  i_flush_all, i_flush_asid, i_flush_asid_id,
    output o_busy
  );

  modport master (
    output i_lookup_valid, i_lookup_vpn, i_asid,
    input  o_hit_valid, o_hit, o_ppn, o_flags,
    output i_fill_valid, i_fill_vpn, i_fill_asid, i_fill_ppn, i_fill_flags,
    input  o_fill_ready,
    output i_flush_all, i_flush_asid, i_flush_asid_id,
    input  o_busy
  );

endinterface
`default_nettype wire

// File: rtl/itlb_victim_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : itlb_victim_sel                                                |
// | Purpose : Combinational refill way choice for one set: an entry already  |
// |           holding the same tag+ASID, else the lowest invalid way, else   |
// |           the set's round-robin pointer.                                 |
// | Ports   : i_tags    tag entries of the addressed set                     |
// |           i_tag     refill tag;  i_asid refill ASID                      |
// |           i_rr_ptr  round-robin pointer of the set                       |
// |           o_way     chosen way;  o_use_rr 1 when the pointer was used    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module itlb_victim_sel
  import itlb_pkg::*;
#(
  parameter int ASSOC  = ITLB_ASSOC,
  parameter int TAG_W  = ITLB_TAG_W,
  parameter int ASID_W = ITLB_ASID_W,
  parameter int WAY_W  = $clog2(ASSOC)
) (
  input  itlb_tag_entry_t   i_tags [ASSOC],
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [ASID_W-1:0] i_asid,
  input  logic [WAY_W-1:0]  i_rr_ptr,
  output logic [WAY_W-1:0]  o_way,
  output logic              o_use_rr
);

  logic             w_match_found;
  logic             w_inv_found;
  logic [WAY_W-1:0] w_match_way;
  logic [WAY_W-1:0] w_inv_way;

  // Scan from the top way down so the lowest-numbered candidate wins.
  always_comb begin
    w_match_found = 1'b0;
    w_inv_found   = 1'b0;
    w_match_way   = '0;
    w_inv_way     = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (i_tags[w].valid && (i_tags[w].tag == i_tag) && (i_tags[w].asid == i_asid)) begin
        w_match_found = 1'b1;
        w_match_way   = WAY_W'(w);
      end
      if (!i_tags[w].valid) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    o_way    = i_rr_ptr;
    o_use_rr = 1'b1;
    if (w_match_found) begin
      o_way    = w_match_way;
      o_use_rr = 1'b0;
    end else if (w_inv_found) begin
      o_way    = w_inv_way;
      o_use_rr = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_tlb_sa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : instr_tlb_sa                                                   |
// | Purpose : Set-associative instruction TLB with ASID tagging, global      |
// |           entries, 1-cycle registered lookup, refill with match/invalid/ |
// |           round-robin replacement, flush-all and a per-ASID flush walk.  |
// | Ports   : i_clk  clock (rising edge)                                     |
// |           i_rst  asynchronous active-high reset                          |
// |           bus    instr_tlb_sa_if.slave: lookup request/result, refill    |
// |                  handshake and payload, flush controls, o_busy           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module instr_tlb_sa
  import itlb_pkg::*;
#(
  parameter int ASSOC  = ITLB_ASSOC,
  parameter int SETS   = ITLB_SETS,
  parameter int VPN_W  = ITLB_VPN_W,
  parameter int PPN_W  = ITLB_PPN_W,
  parameter int ASID_W = ITLB_ASID_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  instr_tlb_sa_if.slave bus
);

  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = VPN_W - SET_W;
  localparam int WAY_W = $clog2(ASSOC);

  // Entry storage (flops). Only tag entries carry the valid bit and are reset;
  // data entries are qualified by valid and need no reset.
  itlb_tag_entry_t  tag_q  [SETS][ASSOC];
  itlb_tag_entry_t  tag_d  [SETS][ASSOC];
  itlb_data_entry_t data_q [SETS][ASSOC];
  logic [WAY_W-1:0] rr_q   [SETS];
  logic [WAY_W-1:0] rr_d   [SETS];

  itlb_state_e       state_q, state_d;
  logic [SET_W-1:0]  cnt_q, cnt_d;
  logic [ASID_W-1:0] fasid_q, fasid_d;

  logic              hit_valid_q;
  logic              hit_q;
  logic [PPN_W-1:0]  ppn_q;
  logic [2:0]        flags_q;

  // ---------------------------------------------------------------- lookup
  logic [SET_W-1:0] w_lk_set;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  itlb_data_entry_t w_lk_data;

  assign w_lk_set = bus.i_lookup_vpn[SET_W-1:0];
  assign w_lk_tag = bus.i_lookup_vpn[VPN_W-1:SET_W];

  // Descending scan: the lowest-numbered hitting way is the last one written.
  always_comb begin
    w_lk_hit  = 1'b0;
    w_lk_data = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (tag_q[w_lk_set][w].valid && (tag_q[w_lk_set][w].tag == w_lk_tag) &&
          (data_q[w_lk_set][w].flags[FLAG_G] || (tag_q[w_lk_set][w].asid == bus.i_asid))) begin
        w_lk_hit  = 1'b1;
        w_lk_data = data_q[w_lk_set][w];
      end
    end
  end

  // A lookup presented during the walk always misses.
  logic w_lk_ok;
  assign w_lk_ok = bus.i_lookup_valid && w_lk_hit && (state_q != WALK);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hit_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      ppn_q       <= '0;
      flags_q     <= '0;
    end else begin
      hit_valid_q <= bus.i_lookup_valid;
      hit_q       <= w_lk_ok;
      ppn_q       <= w_lk_ok ? w_lk_data.ppn   : '0;
      flags_q     <= w_lk_ok ? w_lk_data.flags : '0;
    end
  end

  // ---------------------------------------------------------------- refill
  logic             w_fill_ready;
  logic             w_fill_fire;
  logic [SET_W-1:0] w_fill_set;
  logic [TAG_W-1:0] w_fill_tag;
  logic [WAY_W-1:0] w_fill_way;
  logic             w_fill_use_rr;
  itlb_tag_entry_t  w_fill_tags [ASSOC];

  assign w_fill_ready = (state_q == IDLE) && !bus.i_flush_all && !bus.i_flush_asid;
  assign w_fill_fire  = bus.i_fill_valid && w_fill_ready;
  assign w_fill_set   = bus.i_fill_vpn[SET_W-1:0];
  assign w_fill_tag   = bus.i_fill_vpn[VPN_W-1:SET_W];

  always_comb begin
    for (int w = 0; w < ASSOC; w++) begin
      w_fill_tags[w] = tag_q[w_fill_set][w];
    end
  end

  itlb_victim_sel #(
    .ASSOC  (ASSOC),
    .TAG_W  (TAG_W),
    .ASID_W (ASID_W),
    .WAY_W  (WAY_W)
  ) u_victim_sel (
    .i_tags   (w_fill_tags),
    .i_tag    (w_fill_tag),
    .i_asid   (bus.i_fill_asid),
    .i_rr_ptr (rr_q[w_fill_set]),
    .o_way    (w_fill_way),
    .o_use_rr (w_fill_use_rr)
  );

  // ---------------------------------------------------------------- flush FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fasid_d = fasid_q;
    if (bus.i_flush_all) begin
      // Flush-all dominates: no walk starts, a running walk is abandoned.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_flush_asid) begin
            fasid_d = bus.i_flush_asid_id;
            cnt_d   = '0;
            state_d = WALK;
          end
        end
        WALK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SET_W'(SETS - 1)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fasid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fasid_q <= fasid_d;
    end
  end

  // ---------------------------------------------------------------- array update
  // Flush-all, walk and fill are mutually exclusive: fills are only accepted
  // in IDLE without a flush strobe.
  always_comb begin
    tag_d = tag_q;
    rr_d  = rr_q;
    if (bus.i_flush_all) begin
      for (int s = 0; s < SETS; s++) begin
        rr_d[s] = '0;
        for (int w = 0; w < ASSOC; w++) begin
          tag_d[s][w].valid = 1'b0;
        end
      end
    end else if (state_q == WALK) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (tag_q[cnt_q][w].valid && !data_q[cnt_q][w].flags[FLAG_G] &&
            (tag_q[cnt_q][w].asid == fasid_q)) begin
          tag_d[cnt_q][w].valid = 1'b0;
        end
      end
    end else if (w_fill_fire) begin
      tag_d[w_fill_set][w_fill_way] = '{valid: 1'b1, tag: w_fill_tag, asid: bus.i_fill_asid};
      if (w_fill_use_rr) begin
        rr_d[w_fill_set] = rr_q[w_fill_set] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < ASSOC; w++) begin
          tag_q[s][w] <= '0;
        end
      end
    end else begin
      tag_q <= tag_d;
      rr_q  <= rr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fill_fire) begin
      data_q[w_fill_set][w_fill_way] <= '{ppn: bus.i_fill_ppn, flags: bus.i_fill_flags};
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.o_hit_valid  = hit_valid_q;
  assign bus.o_hit        = hit_q;
  assign bus.o_ppn        = ppn_q;
  assign bus.o_flags      = flags_q;
  assign bus.o_fill_ready = w_fill_ready;
  assign bus.o_busy       = (state_q == WALK);

endmodule
`default_nettype wire

// File: tb/tb_instr_tlb_sa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_instr_tlb_sa                                                |
// | Purpose : Self-checking bench for instr_tlb_sa (ASSOC=4, SETS=16).       |
// |           Lookup expectations are queued when a lookup is driven and     |
// |           compared when o_hit_valid returns.                             |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_instr_tlb_sa;
  import itlb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_tlb_sa_if bus ();

  instr_tlb_sa dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        hit;
    logic [21:0] ppn;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk      = 0;
  int   n_pass     = 0;
  int   busy_cnt   = 0;
  int   rdy_lo_cnt = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Result monitor and walk-length counters, sampled mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.o_busy) busy_cnt++;
    if (bus.o_busy && !bus.o_fill_ready) rdy_lo_cnt++;
    if (bus.o_hit_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk_eq("spurious_hit_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk_eq({e.name, ".hit"},   32'(bus.o_hit),   32'(e.hit));
        chk_eq({e.name, ".ppn"},   32'(bus.o_ppn),   32'(e.ppn));
        chk_eq({e.name, ".flags"}, 32'(bus.o_flags), 32'(e.flags));
      end
    end
  end

  // Start a new cycle just after the rising edge with all strobes low.
  task automatic cyc_start();
    @(posedge clk);
    #1;
    bus.i_lookup_valid = 1'b0;
    bus.i_fill_valid   = 1'b0;
    bus.i_flush_all    = 1'b0;
    bus.i_flush_asid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_start();
  endtask

  task automatic drive_lookup(input logic [19:0] vpn, input logic [8:0] asid, input string name,
                              input logic hit, input logic [21:0] ppn, input logic [2:0] flags);
    exp_t e;
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_vpn   = vpn;
    bus.i_asid         = asid;
    e.name  = name;
    e.hit   = hit;
    e.ppn   = ppn;
    e.flags = flags;
    sb_q.push_back(e);
  endtask

  task automatic lookup(input logic [19:0] vpn, input logic [8:0] asid, input string name,
                        input logic hit, input logic [21:0] ppn, input logic [2:0] flags);
    cyc_start();
    drive_lookup(vpn, asid, name, hit, ppn, flags);
  endtask

  task automatic fill(input logic [19:0] vpn, input logic [8:0] asid,
                      input logic [21:0] ppn, input logic [2:0] flags);
    cyc_start();
    bus.i_fill_valid = 1'b1;
    bus.i_fill_vpn   = vpn;
    bus.i_fill_asid  = asid;
    bus.i_fill_ppn   = ppn;
    bus.i_fill_flags = flags;
    #1 chk_eq("fill_ready", 32'(bus.o_fill_ready), 32'd1);
  endtask

  task automatic flush_all();
    cyc_start();
    bus.i_flush_all = 1'b1;
  endtask

  task automatic flush_asid(input logic [8:0] id);
    cyc_start();
    bus.i_flush_asid    = 1'b1;
    bus.i_flush_asid_id = id;
  endtask

  function automatic logic [19:0] set5_vpn(input int i);
    return 20'((i << 4) | 5);
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    bus.i_lookup_valid  = 1'b0;
    bus.i_lookup_vpn    = '0;
    bus.i_asid          = '0;
    bus.i_fill_valid    = 1'b0;
    bus.i_fill_vpn      = '0;
    bus.i_fill_asid     = '0;
    bus.i_fill_ppn      = '0;
    bus.i_fill_flags    = '0;
    bus.i_flush_all     = 1'b0;
    bus.i_flush_asid    = 1'b0;
    bus.i_flush_asid_id = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk_eq("rst.hit_valid", 32'(bus.o_hit_valid), 32'd0);
    chk_eq("rst.hit",       32'(bus.o_hit),       32'd0);
    chk_eq("rst.ppn",       32'(bus.o_ppn),       32'd0);
    chk_eq("rst.flags",     32'(bus.o_flags),     32'd0);
    chk_eq("rst.busy",      32'(bus.o_busy),      32'd0);
    rst = 1'b0;
    #1 chk_eq("rst.fill_ready", 32'(bus.o_fill_ready), 32'd1);

    // Empty TLB misses
    lookup(20'h12345, 9'd0, "empty", 1'b0, 22'h0, 3'b000);

    // Basic fill, ASID discrimination, global refill
    fill(20'h12345, 9'd3, 22'h0ABCD, 3'b001);
    lookup(20'h12345, 9'd3, "asid3",  1'b1, 22'h0ABCD, 3'b001);
    lookup(20'h12345, 9'd4, "asid4",  1'b0, 22'h0,     3'b000);
    fill(20'h12345, 9'd3, 22'h0ABCD, 3'b101);
    lookup(20'h12345, 9'd4, "glob4",  1'b1, 22'h0ABCD, 3'b101);
    flush_all();
    lookup(20'h12345, 9'd3, "fa_clr", 1'b0, 22'h0,     3'b000);

    // Replacement in set 5
    for (int i = 1; i <= 5; i++) fill(set5_vpn(i), 9'd1, 22'(32'h100 + i), 3'b011);
    lookup(set5_vpn(1), 9'd1, "s5_v1_evicted", 1'b0, 22'h0, 3'b000);
    for (int i = 2; i <= 5; i++) lookup(set5_vpn(i), 9'd1, "s5_hit", 1'b1, 22'(32'h100 + i), 3'b011);
    fill(set5_vpn(6), 9'd1, 22'h106, 3'b011);            // pointer 1 -> evicts vpn 2
    lookup(set5_vpn(2), 9'd1, "s5_v2_evicted", 1'b0, 22'h0,   3'b000);
    lookup(set5_vpn(6), 9'd1, "s5_v6",         1'b1, 22'h106, 3'b011);
    fill(set5_vpn(3), 9'd1, 22'h333, 3'b011);            // overwrite in place
    lookup(set5_vpn(3), 9'd1, "s5_v3_new", 1'b1, 22'h333, 3'b011);
    for (int i = 4; i <= 6; i++) lookup(set5_vpn(i), 9'd1, "s5_kept", 1'b1, 22'(32'h100 + i), 3'b011);
    fill(set5_vpn(7), 9'd1, 22'h107, 3'b011);            // pointer still 2 -> evicts vpn 3
    lookup(set5_vpn(3), 9'd1, "s5_v3_evicted", 1'b0, 22'h0,   3'b000);
    lookup(set5_vpn(4), 9'd1, "s5_v4",         1'b1, 22'h104, 3'b011);
    lookup(set5_vpn(7), 9'd1, "s5_v7",         1'b1, 22'h107, 3'b011);

    // Per-ASID flush walk
    flush_all();
    fill(20'h00100, 9'd3, 22'h0000A, 3'b001);
    fill(20'h00201, 9'd7, 22'h0000B, 3'b001);
    fill(20'h00302, 9'd3, 22'h0000C, 3'b101);
    fill(20'h00413, 9'd3, 22'h0000D, 3'b001);
    flush_asid(9'd3);
    busy_cnt   = 0;
    rdy_lo_cnt = 0;
    lookup(20'h00201, 9'd7, "busy_miss", 1'b0, 22'h0, 3'b000);
    begin : wait_walk
      bit done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        cyc_start();
        if (!bus.o_busy) done = 1'b1;
      end
      if (!done) chk_eq("walk_timeout", 32'd1, 32'd0);
    end
    chk_eq("walk_busy_cycles",  32'(busy_cnt),   32'd16);
    chk_eq("walk_ready_low",    32'(rdy_lo_cnt), 32'd16);
    lookup(20'h00100, 9'd3, "wk_a3_gone", 1'b0, 22'h0,     3'b000);
    lookup(20'h00201, 9'd7, "wk_b7_kept", 1'b1, 22'h0000B, 3'b001);
    lookup(20'h00302, 9'd3, "wk_glob3",   1'b1, 22'h0000C, 3'b101);
    lookup(20'h00302, 9'd9, "wk_glob9",   1'b1, 22'h0000C, 3'b101);
    lookup(20'h00413, 9'd3, "wk_d3_gone", 1'b0, 22'h0,     3'b000);

    // Flush-all and lookup in the same cycle
    cyc_start();
    bus.i_flush_all = 1'b1;
    drive_lookup(20'h00201, 9'd7, "fa_same_cyc", 1'b1, 22'h0000B, 3'b001);
    #1 chk_eq("fa_fill_ready", 32'(bus.o_fill_ready), 32'd0);
    lookup(20'h00201, 9'd7, "fa_next_cyc", 1'b0, 22'h0, 3'b000);

    // Simultaneous flush_all and flush_asid: no walk
    fill(20'h00201, 9'd7, 22'h0000B, 3'b001);
    cyc_start();
    bus.i_flush_all     = 1'b1;
    bus.i_flush_asid    = 1'b1;
    bus.i_flush_asid_id = 9'd7;
    cyc_start();
    chk_eq("both_no_walk", 32'(bus.o_busy), 32'd0);
    lookup(20'h00201, 9'd7, "both_cleared", 1'b0, 22'h0, 3'b000);

    // Asynchronous reset in the middle of a walk
    fill(20'h00201, 9'd7, 22'h0000B, 3'b001);
    flush_asid(9'd5);
    idle(3);
    chk_eq("walk_started", 32'(bus.o_busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk_eq("async_rst.busy",      32'(bus.o_busy),      32'd0);
    chk_eq("async_rst.hit_valid", 32'(bus.o_hit_valid), 32'd0);
    #12 rst = 1'b0;
    cyc_start();
    chk_eq("post_rst.fill_ready", 32'(bus.o_fill_ready), 32'd1);
    lookup(20'h00201, 9'd7, "post_rst_miss", 1'b0, 22'h0, 3'b000);
    idle(3);
    chk_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_tlb_sa.md
INSTR_TLB_SA -- requirements
Module: instr_tlb_sa

Interface
REQ-001 Parameter ASSOC, 4, number of ways per set; power of two, at least 2.
REQ-002 Parameter SETS, 16, number of sets; power of two, at least 2.
REQ-003 Parameter VPN_W, 20, virtual page number width.
REQ-004 Parameter PPN_W, 22, physical page number width.
REQ-005 Parameter ASID_W, 9, address-space identifier width.
REQ-006 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 i_rst  in  1  reset; asynchronous, active-high.
REQ-008 i_lookup_valid  in  1  lookup request this cycle.
REQ-009 i_lookup_vpn  in  VPN_W  virtual page number to translate.
REQ-010 i_asid  in  ASID_W  current ASID for the lookup.
REQ-011 o_hit_valid  out  1  lookup result valid.
REQ-012 o_hit  out  1  translation found.
REQ-013 o_ppn  out  PPN_W  translated physical page number.
REQ-014 o_flags  out  3  entry flags {G,U,X}.
REQ-015 i_fill_valid  in  1  refill request.
REQ-016 o_fill_ready  out  1  refill accepted when both valid and ready are high.
REQ-017 i_fill_vpn, i_fill_asid, i_fill_ppn, i_fill_flags  in  VPN_W/ASID_W/PPN_W/3  refill payload.
REQ-018 i_flush_all  in  1  single-cycle pulse; invalidate every entry.
REQ-019 i_flush_asid  in  1  single-cycle pulse; invalidate non-global entries of i_flush_asid_id.
REQ-020 i_flush_asid_id  in  ASID_W  ASID targeted by a per-ASID flush.
REQ-021 o_busy  out  1  per-ASID flush walk in progress.

Function
REQ-022 Set index SHALL be vpn[log2(SETS)-1:0]; tag SHALL be the remaining upper VPN bits.
REQ-023 A way SHALL hit when it is valid, its tag matches, and either flag G is set or its stored ASID equals i_asid.
REQ-024 Lookup latency SHALL be 1 cycle: o_hit_valid, o_hit, o_ppn and o_flags are registered, and o_hit_valid equals i_lookup_valid delayed by one cycle.
REQ-025 On a miss, or when o_hit_valid=0, o_ppn and o_flags SHALL be 0; on multiple hits, the lowest-numbered way SHALL win.
REQ-026 Lookups SHALL use the pre-edge contents: a fill, flush_all or walk write in the same cycle is not visible until the next cycle.
REQ-027 Lookups issued while o_busy=1 SHALL return o_hit=0.
REQ-028 Fill way selection, in priority order:
  - a valid way whose tag and ASID both match the request;
  - otherwise the lowest-indexed invalid way;
  - otherwise the set's round-robin victim pointer.
REQ-029 The per-set round-robin pointer SHALL advance modulo ASSOC only when it was used as the victim.
REQ-030 o_fill_ready SHALL equal (state==IDLE) & ~i_flush_all & ~i_flush_asid, and is combinational.
REQ-031 Flush_all SHALL clear all valid bits and all round-robin pointers at the next edge; state SHALL remain IDLE.
REQ-032 The FSM SHALL have states IDLE and WALK:
  - i_flush_asid in IDLE latches the ASID, zeroes the set counter and moves to WALK;
  - each WALK cycle invalidates matching non-global ways of one set;
  - the cycle that processes set SETS-1 returns to IDLE.
REQ-033 o_busy SHALL be 1 exactly in WALK, which lasts SETS cycles.
REQ-034 During WALK, i_flush_asid SHALL be ignored; i_flush_all SHALL clear all entries and abort to IDLE.
REQ-035 If i_flush_all and i_flush_asid assert together, flush_all SHALL win and no walk SHALL start.

Reset
REQ-036 While i_rst=1, and immediately on its assertion regardless of clock:
  - all valid bits, round-robin pointers and the set counter SHALL be 0;
  - state SHALL be IDLE;
  - o_hit_valid, o_hit, o_ppn, o_flags and o_busy SHALL be 0.
REQ-037 Reset asserted mid-WALK SHALL abort the walk; o_fill_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-038 A shared package itlb_pkg SHALL hold itlb_tag_entry_t (valid, tag, asid), itlb_data_entry_t (ppn, flags), the flag bit positions G=2, U=1, X=0, and the FSM state enum.
REQ-039 The sub-module itlb_victim_sel SHALL implement the combinational per-set way choice of REQ-028 (match, then invalid, then pointer); entry arrays SHALL be flops.

Verification (ASSOC=4, SETS=16)
REQ-040 Reset, then lookup vpn 0x12345 -> next cycle o_hit_valid=1, o_hit=0, o_ppn=0.
REQ-041 Fill vpn 0x12345, asid 3, ppn 0x0ABCD, flags X, then lookup:
  - asid 3 -> hit, ppn 0x0ABCD, flags 3'b001;
  - asid 4 -> miss;
  - after refilling with G set, asid 4 -> hit.
REQ-042 Five fills with distinct tags into set 5, asid 1 -> the fifth replaces way 0 and the pointer becomes 1; the first VPN misses and the other four hit. A refill of an existing VPN with a new PPN overwrites its way and evicts nothing.
REQ-043 Entries for asid 3 (non-global), asid 7 and a global entry, then a flush_asid pulse for 3:
  - o_busy=1 and o_fill_ready=0 for exactly 16 cycles;
  - afterwards only the asid-7 and global entries hit.
REQ-044 flush_all and a lookup of a resident VPN in the same cycle -> that lookup hits, and the lookup in the following cycle misses.
REQ-045 Async i_rst asserted mid-WALK between clock edges -> o_busy drops to 0 immediately; after release, a lookup of a previously filled VPN misses.
